i2c_txn_arbiter: RTL and testbench
==================================

# i2c_txn_arbiter

Round-robin arbiter and sequencer that shares the single I2C master core between up to N_REQ requesters. Each requester presents a one-byte transaction (7-bit slave address, R/W, write byte). The arbiter grants one requester at a time, launches the master with a single-cycle start pulse, and waits for the master's done or a watchdog timeout. It then returns read data and status to the granted requester only. It sits between the top-level transaction sources and the I2C master core, in the system clock domain.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..8)
- TIMEOUT_CYCLES, 65535, i_Clk cycles allowed from start to m_done before aborting

Ports:
- i_Clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  N_REQ  per-requester transaction request; held until req_done
- req_addr  in  7*N_REQ  packed slave addresses; slice i = [7i+6:7i]
- req_rw  in  N_REQ  1 = read, 0 = write
- req_wdata  in  8*N_REQ  packed write bytes
- req_grant  out  N_REQ  one-hot; marks the owner of the current transaction
- req_done  out  N_REQ  one-cycle completion pulse to the owner
- req_err  out  N_REQ  valid with req_done; 1 = NACK or timeout
- req_rdata  out  8  read byte; valid with req_done when the owner's req_rw = 1
- m_start  out  1  one-cycle launch pulse to the master core
- m_addr  out  7  registered slave address
- m_rw  out  1  registered R/W
- m_wdata  out  8  registered write byte
- m_abort  out  1  one-cycle abort pulse on timeout
- m_busy  in  1  master transaction in progress
- m_done  in  1  one-cycle master completion
- m_nack  in  1  valid with m_done
- m_rdata  in  8  valid with m_done

## Operation
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Latch owner, addr, rw and wdata into m_* registers, assert req_grant[owner], go to ISSUE.
- ISSUE: m_start = 1 for exactly one cycle; clear the watchdog; go to WAIT_BUSY.
- WAIT_BUSY: wait for m_busy = 1, then go to WAIT_DONE. If m_done arrives first (a zero-length master), treat it as seen in WAIT_DONE.
- WAIT_DONE: on m_done, capture m_nack and m_rdata, then go to RESP.
- Timeout: if the watchdog reaches TIMEOUT_CYCLES-1 in WAIT_BUSY or WAIT_DONE, pulse m_abort, set err = 1, rdata = 0x00, go to RESP.
- RESP:
  - req_done[owner] = 1 and req_err[owner] = err for one cycle.
  - Clear req_grant, set rr_ptr = owner+1 mod N_REQ, return to IDLE.
- Requests from non-owners never affect the current transaction. Deasserting req_valid[owner] mid-transaction does not cancel it; it completes normally.
- Watchdog counter width is clog2(TIMEOUT_CYCLES). It saturates and never wraps.
- Reset (reset = 0 at the clock edge), including mid-transaction:
  - state = IDLE, rr_ptr = 0.
  - All outputs are 0: req_grant, req_done, req_err, req_rdata, m_start, m_abort, m_addr, m_rw, m_wdata.
  - The master is not aborted by the arbiter. It shares the same reset.

## Timing
- Arbitration decision to m_start: 1 cycle. req_valid sampled in IDLE at cycle t gives req_grant at t+1 and m_start at t+1 (ISSUE).
- m_addr, m_rw and m_wdata are stable from the ISSUE cycle through RESP.
- m_done at cycle t gives req_done at t+1.
- Back-to-back turnaround: the earliest next grant comes 1 cycle after RESP (the IDLE cycle). The minimum arbiter overhead per transaction is 3 cycles plus master latency.
- Simultaneous m_done and timeout in the same cycle: m_done wins; no abort, err = m_nack.
- req_grant is one-hot or zero at all times. req_done and req_err are zero outside RESP.

## Structure
- Shared package i2c_pkg: state encoding constants, the I2C address width (7) and data width (8). The master core uses the same package.
- Round-robin selection is a natural sub-module, rr_select: combinational inputs valid[N_REQ] and ptr; outputs onehot and index. It is instantiated once.
- The top-level wrapper instantiates i2c_txn_arbiter between the request sources and the master core.

## Test plan
- Single write: req0 with addr 0x50, rw 0, wdata 0xA5; master done after 40 cycles with nack 0 -> m_start once; m_addr = 0x50, m_wdata = 0xA5; req_done[0] with err 0 one cycle after m_done.
- Single read: req1 read from addr 0x3C; master returns m_rdata 0x5E -> req_rdata = 0x5E with req_done[1]; req_done[0] stays 0.
- Contention: req0 and req1 held continuously for 4 transactions -> grants alternate 0,1,0,1; rr_ptr wraps correctly.
- NACK: master returns m_nack = 1 -> req_err[owner] = 1 with req_done; the next grant proceeds normally.
- Timeout: TIMEOUT_CYCLES = 100 and the master never asserts m_done -> m_abort on the 100th cycle after ISSUE, then req_done with err 1; m_done in the same cycle as the limit -> no abort.
- Reset mid-WAIT_DONE: reset = 0 for 1 cycle -> all outputs 0 on the next cycle, state IDLE; a pending req0 is re-granted after reset releases.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, arbiter FSM state encoding and the
// latched transaction record used between the arbiter and the master core.
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_RESP      = 3'd4;

    typedef struct packed {
        logic [I2C_ADDR_W-1:0] addr;
        logic                  rw;
        logic [I2C_DATA_W-1:0] wdata;
    } i2c_txn_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle between the request sources / I2C master core and the arbiter.
// slave = arbiter view, master = view of the surrounding environment.
interface i2c_txn_arbiter_if
    import i2c_pkg::*;
#(
    parameter int N_REQ = 2
) ();

    logic [N_REQ-1:0]            req_valid;
    logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
    logic [N_REQ-1:0]            req_rw;
    logic [I2C_DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]            req_grant;
    logic [N_REQ-1:0]            req_done;
    logic [N_REQ-1:0]            req_err;
    logic [I2C_DATA_W-1:0]       req_rdata;

    logic                        m_start;
    logic [I2C_ADDR_W-1:0]       m_addr;
    logic                        m_rw;
    logic [I2C_DATA_W-1:0]       m_wdata;
    logic                        m_abort;
    logic                        m_busy;
    logic                        m_done;
    logic                        m_nack;
    logic [I2C_DATA_W-1:0]       m_rdata;

    modport slave (
        input  req_valid, req_addr, req_rw, req_wdata,
        output req_grant, req_done, req_err, req_rdata,
        output m_start, m_addr, m_rw, m_wdata, m_abort,
        input  m_busy, m_done, m_nack, m_rdata
    );

    modport master (
        output req_valid, req_addr, req_rw, req_wdata,
        input  req_grant, req_done, req_err, req_rdata,
        input  m_start, m_addr, m_rw, m_wdata, m_abort,
        output m_busy, m_done, m_nack, m_rdata
    );

endinterface

// File: rtl/i2c_txn_arbiter_rr_select.sv
// Combinational round-robin picker: first valid requester at or after ptr_i,
// wrapping modulo N_REQ.
module rr_select #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [IDX_W-1:0] index_o,
    output logic             any_o
);

    logic             found_s;
    logic [IDX_W-1:0] pos_s;

    // scan every requester starting from the pointer, keep the first hit
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        found_s  = 1'b0;
        pos_s    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos_s = IDX_W'((int'(ptr_i) + k) % N_REQ);
            if (!found_s && valid_i[pos_s]) begin
                found_s         = 1'b1;
                onehot_o[pos_s] = 1'b1;
                index_o         = pos_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one I2C master core between N_REQ
// requesters, with a saturating watchdog that aborts a stalled master.
module i2c_txn_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic              i_Clk,
    input logic              reset,
    i2c_txn_arbiter_if.slave bus
);

    localparam int              IDX_W    = $clog2(N_REQ);
    localparam int              WD_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      owner_q, owner_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      done_q, done_d;
    logic [N_REQ-1:0]      err_q, err_d;
    logic [I2C_DATA_W-1:0] rdata_q, rdata_d;
    i2c_txn_t              txn_q, txn_d;
    logic                  start_q, start_d;
    logic                  abort_q, abort_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;

    logic [N_REQ-1:0]      sel_onehot_s;
    logic [IDX_W-1:0]      sel_idx_s;
    logic                  sel_any_s;
    i2c_txn_t              sel_txn_s;
    logic                  timeout_s;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .valid_i  (bus.req_valid),
        .ptr_i    (ptr_q),
        .onehot_o (sel_onehot_s),
        .index_o  (sel_idx_s),
        .any_o    (sel_any_s)
    );

    // extract the selected requester's transaction fields
    always_comb begin
        sel_txn_s.addr  = bus.req_addr[int'(sel_idx_s)*I2C_ADDR_W +: I2C_ADDR_W];
        sel_txn_s.rw    = bus.req_rw[sel_idx_s];
        sel_txn_s.wdata = bus.req_wdata[int'(sel_idx_s)*I2C_DATA_W +: I2C_DATA_W];
    end

    assign timeout_s = (wdog_q == WD_LIMIT);

    // next-state logic; grant_q is one-hot on the owner, so it doubles as the
    // done/err steering mask and non-owners can never be signalled
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        done_d  = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        txn_d   = txn_q;
        start_d = 1'b0;
        abort_d = 1'b0;

        // zero while idle so it reads 0 in ISSUE; saturates instead of wrapping
        if (state_q == ST_IDLE) begin
            wdog_d = '0;
        end else if (wdog_q != WD_MAX) begin
            wdog_d = wdog_q + WD_W'(1);
        end else begin
            wdog_d = wdog_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_any_s) begin
                    owner_d = sel_idx_s;
                    grant_d = sel_onehot_s;
                    txn_d   = sel_txn_s;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    grant_d = '0;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY, ST_WAIT_DONE: begin
                // m_done has priority over a timeout in the same cycle
                if (bus.m_done) begin
                    done_d  = grant_q;
                    err_d   = bus.m_nack ? grant_q : '0;
                    rdata_d = bus.m_rdata;
                    state_d = ST_RESP;
                end else if (timeout_s) begin
                    abort_d = 1'b1;
                    done_d  = grant_q;
                    err_d   = grant_q;
                    rdata_d = 8'h00;
                    state_d = ST_RESP;
                end else if (bus.m_busy) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
                if (owner_q == IDX_W'(N_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = owner_q + IDX_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge i_Clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            txn_q   <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            txn_q   <= txn_d;
            start_q <= start_d;
            abort_q <= abort_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.req_grant = grant_q;
    assign bus.req_done  = done_q;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign bus.m_start   = start_q;
    assign bus.m_abort   = abort_q;
    assign bus.m_addr    = txn_q.addr;
    assign bus.m_rw      = txn_q.rw;
    assign bus.m_wdata   = txn_q.wdata;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: stimulus queues expected launches and
// responses, a negedge monitor pops and compares them, a small master model answers.
module tb_i2c_txn_arbiter;
    import i2c_pkg::*;

    localparam int N  = 2;
    localparam int TO = 100;

    typedef struct {
        int         idx;
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       err;
        logic [7:0] rdata;
        logic       to;
    } exp_t;

    typedef struct {
        int         lat;
        logic       busy_en;
        logic       nack;
        logic [7:0] rdata;
    } mrsp_t;

    logic i_Clk;
    logic reset;

    i2c_txn_arbiter_if #(.N_REQ(N)) bus ();

    i2c_txn_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_Clk (i_Clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  exp_start[$];
    exp_t  exp_resp[$];
    mrsp_t mrsp_q[$];
    exp_t  mon_e;
    int    n_checks     = 0;
    int    n_fail       = 0;
    int    n_starts     = 0;
    int    n_exp_starts = 0;
    int    cyc          = 0;
    int    start_cyc    = 0;
    int    mdone_cyc    = -10;
    logic  kill         = 1'b0;

    initial begin
        i_Clk = 1'b0;
        forever #5 i_Clk = ~i_Clk;
    end

    always @(posedge i_Clk) begin
        cyc <= cyc + 1;
        if (bus.m_done === 1'b1) mdone_cyc <= cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: launches and completions are compared against the queues
    always @(negedge i_Clk) begin
        if (bus.m_start === 1'b1) begin
            n_starts++;
            if (exp_start.size() == 0) begin
                check("start_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_start.pop_front();
                check("start_grant", 32'(bus.req_grant), 32'(1 << mon_e.idx));
                check("start_addr", 32'(bus.m_addr), 32'(mon_e.addr));
                check("start_rw", 32'(bus.m_rw), 32'(mon_e.rw));
                check("start_wdata", 32'(bus.m_wdata), 32'(mon_e.wdata));
                start_cyc = cyc;
            end
        end
        check("grant_onehot0", 32'($onehot0(bus.req_grant)), 32'd1);
        if (bus.req_done !== '0) begin
            if (exp_resp.size() == 0) begin
                check("done_unexpected", 32'(bus.req_done), 32'd0);
            end else begin
                mon_e = exp_resp.pop_front();
                check("done_vec", 32'(bus.req_done), 32'(1 << mon_e.idx));
                check("err_vec", 32'(bus.req_err), mon_e.err ? 32'(1 << mon_e.idx) : 32'd0);
                if (mon_e.rw) check("rdata", 32'(bus.req_rdata), 32'(mon_e.rdata));
                check("hold_addr", 32'(bus.m_addr), 32'(mon_e.addr));
                check("hold_wdata", 32'(bus.m_wdata), 32'(mon_e.wdata));
                check("abort_with_done", 32'(bus.m_abort), 32'(mon_e.to));
                if (mon_e.to) check("timeout_cycle", 32'(cyc - start_cyc), 32'(TO));
                else          check("done_latency", 32'(cyc - mdone_cyc), 32'd1);
            end
        end else begin
            check("idle_err_abort", 32'({bus.req_err, bus.m_abort}), 32'd0);
        end
    end

    // master core model: busy after launch, m_done after lat cycles (0 = never)
    initial begin
        mrsp_t r;
        int    k;
        bus.m_busy  = 1'b0;
        bus.m_done  = 1'b0;
        bus.m_nack  = 1'b0;
        bus.m_rdata = 8'h00;
        forever begin
            @(negedge i_Clk);
            if (bus.m_start === 1'b1 && mrsp_q.size() != 0) begin
                r = mrsp_q.pop_front();
                bus.m_busy = r.busy_en;
                k = 0;
                while (k < 400) begin
                    @(negedge i_Clk);
                    k++;
                    if (kill || bus.m_abort === 1'b1) break;
                    if (r.lat != 0 && k == r.lat) begin
                        bus.m_done  = 1'b1;
                        bus.m_nack  = r.nack;
                        bus.m_rdata = r.rdata;
                        @(negedge i_Clk);
                        break;
                    end
                end
                kill        = 1'b0;
                bus.m_busy  = 1'b0;
                bus.m_done  = 1'b0;
                bus.m_nack  = 1'b0;
                bus.m_rdata = 8'h00;
            end
        end
    end

    task automatic push_txn(input int idx, input logic [6:0] addr, input logic rw,
                            input logic [7:0] wdata, input int lat, input logic busy_en,
                            input logic nack, input logic [7:0] rdata);
        exp_t  e;
        mrsp_t r;
        e.idx   = idx;
        e.addr  = addr;
        e.rw    = rw;
        e.wdata = wdata;
        e.to    = (lat == 0);
        e.err   = nack | e.to;
        e.rdata = e.to ? 8'h00 : rdata;
        r.lat     = lat;
        r.busy_en = busy_en;
        r.nack    = nack;
        r.rdata   = rdata;
        exp_start.push_back(e);
        exp_resp.push_back(e);
        mrsp_q.push_back(r);
        n_exp_starts++;
    endtask

    task automatic set_req(input int idx, input logic [6:0] addr, input logic rw, input logic [7:0] wdata);
        bus.req_addr[idx*7 +: 7]  = addr;
        bus.req_rw[idx]           = rw;
        bus.req_wdata[idx*8 +: 8] = wdata;
        bus.req_valid[idx]        = 1'b1;
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while (exp_resp.size() != 0 && k < bound) begin
            @(negedge i_Clk);
            k++;
        end
        check({name, "_outstanding"}, 32'(exp_resp.size()), 32'd0);
        if (exp_resp.size() != 0) begin
            exp_resp.delete();
            exp_start.delete();
            mrsp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.req_grant), 32'd0);
        check({tag, "_done"},  32'(bus.req_done),  32'd0);
        check({tag, "_err"},   32'(bus.req_err),   32'd0);
        check({tag, "_rdata"}, 32'(bus.req_rdata), 32'd0);
        check({tag, "_start"}, 32'(bus.m_start),   32'd0);
        check({tag, "_abort"}, 32'(bus.m_abort),   32'd0);
        check({tag, "_addr"},  32'(bus.m_addr),    32'd0);
        check({tag, "_rw"},    32'(bus.m_rw),      32'd0);
        check({tag, "_wdata"}, 32'(bus.m_wdata),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "global time limit expired");
    end

    initial begin
        int k;
        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_rw    = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge i_Clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge i_Clk);

        // single write from req0, master finishes after 40 cycles
        push_txn(0, 7'h50, 1'b0, 8'hA5, 40, 1'b1, 1'b0, 8'h00);
        set_req(0, 7'h50, 1'b0, 8'hA5);
        drain("write", 200);
        bus.req_valid = '0;

        // single read from req1
        push_txn(1, 7'h3C, 1'b1, 8'h00, 10, 1'b1, 1'b0, 8'h5E);
        set_req(1, 7'h3C, 1'b1, 8'h00);
        drain("read", 200);
        bus.req_valid = '0;

        // contention: both held for four transactions, grants alternate 0,1,0,1
        push_txn(0, 7'h11, 1'b0, 8'h01, 5, 1'b1, 1'b0, 8'h00);
        push_txn(1, 7'h22, 1'b1, 8'h00, 5, 1'b1, 1'b0, 8'h81);
        push_txn(0, 7'h11, 1'b0, 8'h01, 5, 1'b1, 1'b0, 8'h00);
        push_txn(1, 7'h22, 1'b1, 8'h00, 5, 1'b1, 1'b0, 8'h82);
        set_req(0, 7'h11, 1'b0, 8'h01);
        set_req(1, 7'h22, 1'b1, 8'h00);
        drain("contention", 300);
        bus.req_valid = '0;

        // NACK, then a normal zero-length (no busy) transaction
        push_txn(1, 7'h2A, 1'b0, 8'h3C, 6, 1'b1, 1'b1, 8'h00);
        set_req(1, 7'h2A, 1'b0, 8'h3C);
        drain("nack", 200);
        bus.req_valid = '0;
        push_txn(0, 7'h61, 1'b0, 8'h5A, 3, 1'b0, 1'b0, 8'h00);
        set_req(0, 7'h61, 1'b0, 8'h5A);
        drain("zero_len", 200);
        bus.req_valid = '0;

        // watchdog expiry, then m_done exactly on the limit cycle
        push_txn(1, 7'h33, 1'b1, 8'h00, 0, 1'b1, 1'b0, 8'hEE);
        set_req(1, 7'h33, 1'b1, 8'h00);
        drain("timeout", 300);
        bus.req_valid = '0;
        push_txn(0, 7'h34, 1'b1, 8'h00, TO - 1, 1'b1, 1'b0, 8'h77);
        set_req(0, 7'h34, 1'b1, 8'h00);
        drain("limit_done", 300);
        bus.req_valid = '0;

        // reset in WAIT_DONE while req0 is pending; req0 must win afterwards
        push_txn(1, 7'h44, 1'b0, 8'h99, 60, 1'b1, 1'b0, 8'h00);
        set_req(1, 7'h44, 1'b0, 8'h99);
        k = 0;
        while (exp_start.size() != 0 && k < 50) begin
            @(negedge i_Clk);
            k++;
        end
        check("reset_txn_started", 32'(exp_start.size()), 32'd0);
        set_req(0, 7'h55, 1'b1, 8'h00);
        repeat (10) @(negedge i_Clk);
        reset = 1'b0;
        kill  = 1'b1;
        exp_resp.delete();
        @(negedge i_Clk);
        check_all_zero("midreset");
        reset = 1'b1;
        push_txn(0, 7'h55, 1'b1, 8'h00, 4, 1'b1, 1'b0, 8'hC3);
        push_txn(1, 7'h44, 1'b0, 8'h99, 4, 1'b1, 1'b0, 8'h00);
        drain("after_reset", 200);
        bus.req_valid = '0;

        repeat (5) @(negedge i_Clk);
        check("start_count", 32'(n_starts), 32'(n_exp_starts));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
